eth_tx_frame_fifo: RTL and testbench

Store-and-forward AXI4-Stream frame FIFO that sits directly downstream of the TX frame generator (eth_encap) and upstream of the 10G MAC TX interface, all in the clk156 domain. It accepts 64-bit beats and holds each frame until its tlast beat has been written and committed. Only complete, good frames are released to the MAC, so m_axis_tvalid never de-asserts inside a frame (MAC underrun-safe). Frames with upstream errors, and frames that overflow the buffer, are discarded and counted.

---
 rtl/eth_tx_frame_fifo.sv | 195 +++++++++++++++++++
 tb/tb_eth_tx_frame_fifo.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_frame_fifo.sv
// Store-and-forward AXI4-Stream frame FIFO between eth_encap and 10G MAC TX.
// Ports: s_axis_* (64b beats in), m_axis_* (complete good frames out),
//        frame_cnt / drop_ovf_cnt / drop_bad_cnt saturating status counters.
module eth_tx_frame_fifo #(
  parameter int DEPTH_LOG2 = 9,
  parameter int CNT_W      = 16
) (
  input  logic             clk156,
  input  logic             eth_rst,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [63:0]      s_axis_tdata,
  input  logic [7:0]       s_axis_tkeep,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  input  logic             m_axis_tready,
  output logic             m_axis_tvalid,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_ovf_cnt,
  output logic [CNT_W-1:0] drop_bad_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FRAME,
    W_DROP
  } wstate_t;

  wstate_t wstate, wstate_nxt;

  logic [PW-1:0] wr_ptr, wr_commit, rd_ptr;
  logic          full, avail, beat;

  logic ram_we, rewind, do_commit;
  logic inc_frame, inc_ovf, inc_bad;

  logic [72:0] mem [DEPTH];
  logic [72:0] ram_q;
  logic        rd_en;

  logic [72:0] sk [2];
  logic        sk_hd, sk_tl;
  logic [1:0]  ocnt, occ_next;
  logic        rd_pend;
  logic        out_valid, pop, push, pop_sk;
  logic [72:0] out_word;

  // Never backpressures; ready only drops while reset is held.
  assign s_axis_tready = !eth_rst;
  assign beat  = s_axis_tvalid && s_axis_tready;
  // Full uses rd_ptr before this cycle's read, so it is conservative.
  assign full  = (wr_ptr - rd_ptr) == PW'(DEPTH);
  assign avail = rd_ptr != wr_commit;

  always_ff @(posedge clk156) begin
    if (eth_rst) wstate <= W_IDLE;
    else         wstate <= wstate_nxt;
  end

  always_comb begin
    wstate_nxt = wstate;
    if (beat) begin
      unique case (wstate)
        W_IDLE, W_FRAME: begin
          if (s_axis_tlast) wstate_nxt = W_IDLE;
          else if (full)    wstate_nxt = W_DROP;
          else              wstate_nxt = W_FRAME;
        end
        W_DROP: begin
          if (s_axis_tlast) wstate_nxt = W_IDLE;
        end
        default: wstate_nxt = W_IDLE;
      endcase
    end
  end

  // Overflow is checked before tuser, so an overflowed bad frame
  // is counted only as an overflow drop.
  always_comb begin
    ram_we    = 1'b0;
    rewind    = 1'b0;
    do_commit = 1'b0;
    inc_frame = 1'b0;
    inc_ovf   = 1'b0;
    inc_bad   = 1'b0;
    if (beat) begin
      unique case (wstate)
        W_IDLE, W_FRAME: begin
          if (full) begin
            if (s_axis_tlast) begin
              rewind  = 1'b1;
              inc_ovf = 1'b1;
            end
          end else begin
            ram_we = 1'b1;
            if (s_axis_tlast) begin
              if (s_axis_tuser) begin
                rewind  = 1'b1;
                inc_bad = 1'b1;
              end else begin
                do_commit = 1'b1;
                inc_frame = 1'b1;
              end
            end
          end
        end
        W_DROP: begin
          if (s_axis_tlast) begin
            rewind  = 1'b1;
            inc_ovf = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      wr_ptr       <= '0;
      wr_commit    <= '0;
      rd_ptr       <= '0;
      frame_cnt    <= '0;
      drop_ovf_cnt <= '0;
      drop_bad_cnt <= '0;
    end else begin
      if (rewind)      wr_ptr <= wr_commit;
      else if (ram_we) wr_ptr <= wr_ptr + PW'(1);
      if (do_commit)   wr_commit <= wr_ptr + PW'(1);
      if (rd_en)       rd_ptr <= rd_ptr + PW'(1);
      frame_cnt    <= sat_inc(frame_cnt, inc_frame);
      drop_ovf_cnt <= sat_inc(drop_ovf_cnt, inc_ovf);
      drop_bad_cnt <= sat_inc(drop_bad_cnt, inc_bad);
    end
  end

  always_ff @(posedge clk156) begin
    if (ram_we)
      mem[wr_ptr[DEPTH_LOG2-1:0]] <=
        {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    if (rd_en)
      ram_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
  end

  // RAM output bypasses the skid pair when it is empty, giving
  // first-word-fall-through with a single read cycle of latency.
  assign out_valid = (ocnt != 2'd0) || rd_pend;
  assign out_word  = (ocnt != 2'd0) ? sk[sk_hd] : ram_q;
  assign pop       = out_valid && m_axis_tready;
  assign pop_sk    = pop && (ocnt != 2'd0);
  assign push      = rd_pend && !((ocnt == 2'd0) && pop);
  assign occ_next  = ocnt + {1'b0, rd_pend} - {1'b0, pop};
  // Issue a read only if the word can land even if the MAC stalls.
  assign rd_en     = !eth_rst && avail && (occ_next < 2'd2);

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      sk[0]   <= '0;
      sk[1]   <= '0;
      sk_hd   <= 1'b0;
      sk_tl   <= 1'b0;
      ocnt    <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= rd_en;
      if (push) begin
        sk[sk_tl] <= ram_q;
        sk_tl     <= ~sk_tl;
      end
      if (pop_sk) sk_hd <= ~sk_hd;
      ocnt <= ocnt + {1'b0, push} - {1'b0, pop_sk};
    end
  end

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_valid ? out_word[63:0] : '0;
  assign m_axis_tkeep  = out_valid ? out_word[71:64] : '0;
  assign m_axis_tlast  = out_valid && out_word[72];
  assign m_axis_tuser  = 1'b0;

endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// Directed self-checking bench for eth_tx_frame_fifo (16-word buffer).
// Drives frames, records accepted output beats and compares to expected.
module tb_eth_tx_frame_fifo;

  localparam int DL2 = 4;
  localparam int CW  = 16;

  logic          clk156 = 1'b0;
  logic          eth_rst;
  logic          s_tvalid, s_tready, s_tlast, s_tuser;
  logic [63:0]   s_tdata;
  logic [7:0]    s_tkeep;
  logic          m_tready, m_tvalid, m_tlast, m_tuser;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic [CW-1:0] frame_cnt, drop_ovf_cnt, drop_bad_cnt;

  eth_tx_frame_fifo #(.DEPTH_LOG2(DL2), .CNT_W(CW)) dut (
    .clk156        (clk156),
    .eth_rst       (eth_rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .m_axis_tready (m_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .frame_cnt     (frame_cnt),
    .drop_ovf_cnt  (drop_ovf_cnt),
    .drop_bad_cnt  (drop_bad_cnt)
  );

  always #5 clk156 = ~clk156;

  int cyc = 0;
  always @(posedge clk156) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int last_cyc = 0;

  logic [63:0] out_d[$];
  logic [7:0]  out_k[$];
  logic        out_l[$];
  int          out_c[$];
  logic [63:0] exp_d[$];
  logic [7:0]  exp_k[$];
  logic        exp_l[$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic        prev_stall = 1'b0;
  logic        mid = 1'b0;
  logic [63:0] prev_d;
  logic [7:0]  prev_k;
  logic        prev_l;

  always @(negedge clk156) begin
    if (eth_rst) begin
      prev_stall = 1'b0;
      mid        = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(m_tvalid), 64'd1);
        check("hold_data", m_tdata, prev_d);
        check("hold_keep", 64'(m_tkeep), 64'(prev_k));
        check("hold_last", 64'(m_tlast), 64'(prev_l));
      end
      if (mid) check("no_gap", 64'(m_tvalid), 64'd1);
      check("tuser_out", 64'(m_tuser), 64'd0);
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_k = m_tkeep;
      prev_l = m_tlast;
      if (m_tvalid && m_tready) begin
        out_d.push_back(m_tdata);
        out_k.push_back(m_tkeep);
        out_l.push_back(m_tlast);
        out_c.push_back(cyc);
        mid = !m_tlast;
      end
    end
  end

  task automatic clear_q();
    out_d.delete(); out_k.delete(); out_l.delete(); out_c.delete();
    exp_d.delete(); exp_k.delete(); exp_l.delete();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk156);
      #1;
    end
  endtask

  task automatic do_reset();
    eth_rst  = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    step(2);
    eth_rst = 1'b0;
    clear_q();
  endtask

  task automatic send_frame(input int id, input int n, input logic [7:0] lk,
                            input logic bad, input bit expo,
                            input int rst_beat);
    for (int b = 0; b < n; b++) begin
      s_tvalid = 1'b1;
      s_tdata  = {id[31:0], b[31:0]};
      s_tkeep  = (b == n - 1) ? lk : 8'hFF;
      s_tlast  = (b == n - 1);
      s_tuser  = (b == n - 1) ? bad : 1'b1;
      if (b == rst_beat) begin
        check("valid_at_rst", 64'(m_tvalid), 64'd1);
        eth_rst = 1'b1;
        step(1);
        eth_rst  = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        clear_q();
        @(negedge clk156);
        check("rst_valid", 64'(m_tvalid), 64'd0);
        check("rst_data", m_tdata, 64'd0);
        check("rst_last", 64'(m_tlast), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_s_ready", 64'(s_tready), 64'd1);
        step(1);
        return;
      end
      if (expo) begin
        exp_d.push_back(s_tdata);
        exp_k.push_back(s_tkeep);
        exp_l.push_back(s_tlast);
      end
      step(1);
      if (b == n - 1) last_cyc = cyc;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic drain(input int n);
    int i = 0;
    while (out_d.size() < n && i < 300) begin
      step(1);
      i++;
    end
    check("drain_beats", 64'(out_d.size()), 64'(n));
  endtask

  task automatic cmp_out(input string t);
    check({t, "_beats"}, 64'(out_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < out_d.size() && i < exp_d.size(); i++) begin
      check($sformatf("%s_data[%0d]", t, i), out_d[i], exp_d[i]);
      check($sformatf("%s_keep[%0d]", t, i), 64'(out_k[i]), 64'(exp_k[i]));
      check($sformatf("%s_last[%0d]", t, i), 64'(out_l[i]), 64'(exp_l[i]));
    end
    clear_q();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    eth_rst  = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    m_tready = 1'b1;

    // reset state
    repeat (2) @(posedge clk156);
    @(negedge clk156);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", m_tdata, 64'd0);
    check("rst_m_tkeep", 64'(m_tkeep), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_ovf_cnt", 64'(drop_ovf_cnt), 64'd0);
    check("rst_bad_cnt", 64'(drop_bad_cnt), 64'd0);
    @(posedge clk156);
    #1;
    eth_rst = 1'b0;
    clear_q();
    @(negedge clk156);
    check("s_tready_after_rst", 64'(s_tready), 64'd1);
    step(1);

    // single 10-beat frame, latency and streaming
    send_frame(1, 10, 8'hFF, 1'b0, 1'b1, -1);
    drain(10);
    if (out_c.size() >= 10) begin
      check("t1_latency", 64'(out_c[0] - last_cyc), 64'd1);
      check("t1_span", 64'(out_c[9] - out_c[0]), 64'd9);
    end
    cmp_out("t1");
    check("t1_frame_cnt", 64'(frame_cnt), 64'd1);

    // two back-to-back frames, tready toggling
    do_reset();
    m_tready = 1'b0;
    fork
      begin
        send_frame(2, 10, 8'hFF, 1'b0, 1'b1, -1);
        send_frame(3, 10, 8'hFF, 1'b0, 1'b1, -1);
      end
      begin
        repeat (60) begin
          m_tready = ~m_tready;
          step(1);
        end
        m_tready = 1'b1;
      end
    join
    drain(20);
    cmp_out("t2");
    check("t2_frame_cnt", 64'(frame_cnt), 64'd2);
    check("t2_ovf_cnt", 64'(drop_ovf_cnt), 64'd0);

    // bad frame dropped, good short-keep frame passes
    do_reset();
    m_tready = 1'b1;
    send_frame(4, 5, 8'hFF, 1'b1, 1'b0, -1);
    send_frame(5, 6, 8'h0F, 1'b0, 1'b1, -1);
    drain(6);
    step(5);
    cmp_out("t3");
    check("t3_bad_cnt", 64'(drop_bad_cnt), 64'd1);
    check("t3_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t3_ovf_cnt", 64'(drop_ovf_cnt), 64'd0);

    // oversize frame dropped, then normal frame
    do_reset();
    m_tready = 1'b0;
    send_frame(6, 20, 8'hFF, 1'b0, 1'b0, -1);
    step(20);
    check("t4_no_out", 64'(out_d.size()), 64'd0);
    check("t4_valid", 64'(m_tvalid), 64'd0);
    check("t4_ovf_cnt", 64'(drop_ovf_cnt), 64'd1);
    check("t4_frame_cnt0", 64'(frame_cnt), 64'd0);
    m_tready = 1'b1;
    send_frame(7, 10, 8'hFF, 1'b0, 1'b1, -1);
    drain(10);
    cmp_out("t4");
    check("t4_frame_cnt", 64'(frame_cnt), 64'd1);

    // second frame overflows behind a committed 12-beat frame
    do_reset();
    m_tready = 1'b0;
    send_frame(8, 12, 8'hFF, 1'b0, 1'b1, -1);
    send_frame(9, 8, 8'hFF, 1'b0, 1'b0, -1);
    step(10);
    check("t5_ovf_cnt", 64'(drop_ovf_cnt), 64'd1);
    check("t5_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t5_head_valid", 64'(m_tvalid), 64'd1);
    check("t5_head_data", m_tdata, {32'd8, 32'd0});
    m_tready = 1'b1;
    drain(12);
    step(10);
    cmp_out("t5");

    // reset mid-input and mid-output
    do_reset();
    m_tready = 1'b1;
    send_frame(10, 10, 8'hFF, 1'b0, 1'b0, -1);
    send_frame(11, 10, 8'hFF, 1'b0, 1'b0, 3);
    step(10);
    check("t6_no_out", 64'(out_d.size()), 64'd0);
    check("t6_idle_valid", 64'(m_tvalid), 64'd0);
    send_frame(12, 10, 8'hFF, 1'b0, 1'b1, -1);
    drain(10);
    step(5);
    cmp_out("t6");
    check("t6_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t6_ovf_cnt", 64'(drop_ovf_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
